// File: rtl/jk_cmd_sequencer.sv
// Command FIFO plus CLR/SETTLE/RUN sequencer that drives registered J/K to a JK flop bank.
// Optional shadow model and q mismatch checker, built when JK_SEQ_CHECK_EN is defined.

`ifdef JK_SEQ_CHECK_EN
module jk_seq_lane (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_upd,
  input  logic i_clr,
  input  logic i_chk,
  input  logic i_j,
  input  logic i_k,
  input  logic i_q,
  output logic o_err_nxt,
  output logic o_err
);
  logic r_shadow;
  logic r_err;
  logic w_sh_nxt;
  logic w_err_nxt;

  always_comb begin
    w_sh_nxt = r_shadow;
    case ({i_j, i_k})
      2'b01:   w_sh_nxt = 1'b1;
      2'b10:   w_sh_nxt = 1'b0;
      2'b11:   w_sh_nxt = ~r_shadow;
      default: w_sh_nxt = r_shadow;
    endcase
  end

  assign w_err_nxt = r_err | (i_chk & (i_q ^ r_shadow));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_shadow <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (i_clr)      r_shadow <= 1'b0;
      else if (i_upd) r_shadow <= w_sh_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign o_err_nxt = w_err_nxt;
  assign o_err     = r_err;
endmodule
`endif

module jk_cmd_sequencer #(
  parameter int LANES = 4,
  parameter int DEPTH = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic [2*LANES-1:0]         i_cmd_op,
  output logic [LANES-1:0]           o_j,
  output logic [LANES-1:0]           o_k,
  input  logic [LANES-1:0]           i_q_in,
  output logic                       o_busy,
  output logic [$clog2(DEPTH+1)-1:0] o_fill,
  output logic                       o_err,
  output logic [LANES-1:0]           o_err_lanes
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {S_CLR, S_SETTLE, S_RUN} state_t;

  state_t                 r_state, w_state_nxt;
  logic [2*LANES-1:0]     r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [FW-1:0]          r_fill;
  logic [LANES-1:0]       r_j, r_k, w_j_nxt, w_k_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   w_push, w_pop;
  logic [2*LANES-1:0]     w_head;

  // A full FIFO refuses a push even if it pops this cycle.
  assign o_cmd_ready = (r_fill != FW'(DEPTH));
  assign w_push      = i_cmd_valid && o_cmd_ready;
  assign w_pop       = (r_state == S_RUN) && (r_fill != '0);
  assign w_head      = r_mem[r_rd_ptr];

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_cmd_op;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_fill <= r_fill + FW'(1);
      else if (w_pop && !w_push) r_fill <= r_fill - FW'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_CLR;
      r_j     <= '0;
      r_k     <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_j     <= w_j_nxt;
      r_k     <= w_k_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_j_nxt     = '0;
    w_k_nxt     = '0;
    w_busy_nxt  = r_busy;
    case (r_state)
      S_CLR: begin
        w_j_nxt     = '1;
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Op bits are {j,k} per lane, so the head unpacks straight onto the flops.
        if (w_pop) begin
          for (int i = 0; i < LANES; i++) begin
            w_j_nxt[i] = w_head[2*i+1];
            w_k_nxt[i] = w_head[2*i];
          end
        end
      end
      default: w_state_nxt = S_CLR;
    endcase
  end

  assign o_j    = r_j;
  assign o_k    = r_k;
  assign o_busy = r_busy;
  assign o_fill = r_fill;

`ifdef JK_SEQ_CHECK_EN
  logic             r_armed;
  logic             r_err;
  logic [LANES-1:0] w_err_lanes_nxt;
  logic [LANES-1:0] w_err_lanes;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_armed <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_SETTLE) r_armed <= 1'b1;
      r_err <= |w_err_lanes_nxt;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    jk_seq_lane u_lane (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_upd     (r_state == S_RUN),
      .i_clr     (r_state == S_SETTLE),
      .i_chk     ((r_state == S_RUN) && r_armed),
      .i_j       (r_j[g]),
      .i_k       (r_k[g]),
      .i_q       (i_q_in[g]),
      .o_err_nxt (w_err_lanes_nxt[g]),
      .o_err     (w_err_lanes[g])
    );
  end

  assign o_err       = r_err;
  assign o_err_lanes = w_err_lanes;
`else
  logic w_unused_q;
  assign w_unused_q  = ^i_q_in;
  assign o_err       = 1'b0;
  assign o_err_lanes = '0;
`endif
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer: queue-based reference model compared every cycle,
// plus hand-computed literal checks for each scenario.
module tb_jk_cmd_sequencer;
  localparam int LANES = 4;
  localparam int DEPTH = 4;
  localparam int FW    = $clog2(DEPTH+1);
`ifdef JK_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, valid, ready, busy, err;
  logic [7:0]    op;
  logic [3:0]    j, k, q_in, errl;
  logic [FW-1:0] fill;
  logic [3:0]    fq = 4'b0110;
  logic [3:0]    force_mask = 4'b0000;
  int            checks = 0;
  int            failures = 0;

  assign q_in = fq | force_mask;

  jk_cmd_sequencer #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .i_clock(clk), .i_reset(rst), .i_cmd_valid(valid), .o_cmd_ready(ready),
    .i_cmd_op(op), .o_j(j), .o_k(k), .i_q_in(q_in), .o_busy(busy),
    .o_fill(fill), .o_err(err), .o_err_lanes(errl)
  );

  function automatic logic jk_next(input logic q, input logic jj, input logic kk);
    if (jj && kk) return ~q;
    if (jj)       return 1'b0;
    if (kk)       return 1'b1;
    return q;
  endfunction

  // External flop bank: not reset, follows the J/K it samples.
  always @(posedge clk) begin : flops
    logic [3:0] n;
    n = fq;
    for (int i = 0; i < LANES; i++)
      if ((j[i] === 1'b0 || j[i] === 1'b1) && (k[i] === 1'b0 || k[i] === 1'b1))
        n[i] = jk_next(fq[i], j[i], k[i]);
    fq <= n;
  end

  // Reference model: phase counter, command queue, expected outputs.
  logic [7:0] mq[$];
  int         mphase;
  logic [3:0] mj, mk, msh, merrl;
  logic       mbusy, merr;
  bit         mlive = 1'b0;
  bit         mpush;
  logic [7:0] mh;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mphase = 0; mj = '0; mk = '0; msh = '0; merrl = '0; merr = 1'b0; mbusy = 1'b1;
      mlive = 1'b1;
    end else begin
      mpush = valid && (mq.size() < DEPTH);
      case (mphase)
        0: begin mj = 4'hF; mk = '0; mphase = 1; end
        1: begin mj = '0; mk = '0; msh = '0; mbusy = 1'b0; mphase = 2; end
        default: begin
          if (CHK) begin
            merrl = merrl | (q_in ^ msh);
            merr  = |merrl;
          end
          for (int i = 0; i < LANES; i++) msh[i] = jk_next(msh[i], mj[i], mk[i]);
          if (mq.size() > 0) begin
            mh = mq.pop_front();
            for (int i = 0; i < LANES; i++) begin
              mj[i] = mh[2*i+1];
              mk[i] = mh[2*i];
            end
          end else begin
            mj = '0; mk = '0;
          end
        end
      endcase
      if (mpush) mq.push_back(op);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mlive) begin
      chk("m_j", 32'(j), 32'(mj));
      chk("m_k", 32'(k), 32'(mk));
      chk("m_busy", 32'(busy), 32'(mbusy));
      chk("m_fill", 32'(fill), 32'(mq.size()));
      chk("m_ready", 32'(ready), 32'(mq.size() != DEPTH));
      chk("m_err", 32'(err), 32'(merr));
      chk("m_err_lanes", 32'(errl), 32'(merrl));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; op = '0;
    tick(); tick();
    // 1: reset then idle
    rst = 1'b0;
    tick();
    chk("t1_j_clr", 32'(j), 32'hF);
    chk("t1_busy_clr", 32'(busy), 32'd1);
    tick();
    chk("t1_jk_settle", 32'({j, k}), 32'h00);
    chk("t1_busy_run", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("t1_q_cleared", 32'(q_in), 32'h0);
    chk("t1_err", 32'(err), 32'd0);
    // 4: two toggle-all commands back to back
    valid = 1'b1; op = 8'hFF;
    tick(); tick();
    valid = 1'b0;
    chk("t4_jk", 32'({j, k}), 32'hFF);
    tick();
    chk("t4_q_F", 32'(q_in), 32'hF);
    tick();
    chk("t4_q_0", 32'(q_in), 32'h0);
    chk("t4_jk_idle", 32'({j, k}), 32'h00);
    tick();
    chk("t4_err", 32'(err), 32'd0);
    // 2: one mixed command
    valid = 1'b1; op = 8'b11_10_01_00;
    tick();
    valid = 1'b0;
    chk("t2_fill", 32'(fill), 32'd1);
    tick();
    chk("t2_j", 32'(j), 32'b1100);
    chk("t2_k", 32'(k), 32'b1010);
    tick();
    chk("t2_jk_idle", 32'({j, k}), 32'h00);
    tick();
    chk("t2_q", 32'(q_in), 32'b1010);
    tick();
    chk("t2_err", 32'(err), 32'd0);
    // 3: five back-to-back commands starting in CLR
    rst = 1'b1; tick();
    rst = 1'b0; valid = 1'b1; op = 8'h1B;
    tick(); chk("t3_fill_e1", 32'(fill), 32'd1);
    op = 8'hE4;
    tick(); chk("t3_fill_e2", 32'(fill), 32'd2);
    op = 8'h55; tick();
    op = 8'hAA; tick();
    op = 8'h99; tick();
    valid = 1'b0;
    chk("t3_fill_peak", 32'(fill), 32'd2);
    tick(); chk("t3_fill_drain1", 32'(fill), 32'd1);
    tick(); chk("t3_fill_drain0", 32'(fill), 32'd0);
    repeat (3) tick();
    // 5: forced mismatch on lane 2
    rst = 1'b1; tick();
    rst = 1'b0; repeat (4) tick();
    force_mask = 4'b0100;
    tick();
    force_mask = 4'b0000;
    chk("t5_err_lanes", 32'(errl), CHK ? 32'b0100 : 32'b0);
    chk("t5_err", 32'(err), 32'(CHK));
    repeat (3) tick();
    chk("t5_err_lanes_sticky", 32'(errl), CHK ? 32'b0100 : 32'b0);
    chk("t5_err_sticky", 32'(err), 32'(CHK));
    // 6: reset with FIFO holding entries
    rst = 1'b1; tick();
    rst = 1'b0; valid = 1'b1; op = 8'hFF;
    tick(); tick();
    chk("t6_fill_pre", 32'(fill), 32'd2);
    valid = 1'b0; rst = 1'b1;
    tick();
    chk("t6_fill_rst", 32'(fill), 32'd0);
    chk("t6_jk_rst", 32'({j, k}), 32'h00);
    chk("t6_busy_rst", 32'(busy), 32'd1);
    chk("t6_err_rst", 32'({err, errl}), 32'd0);
    rst = 1'b0;
    tick();
    chk("t6_j_clr", 32'(j), 32'hF);
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t6_no_stale", 32'({j, k}), 32'h00);
    end
    chk("t6_q_cleared", 32'(q_in), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
